// File: rtl/silife_grid.sv
// Cellular-automaton grid (Life-like rules) that computes one generation per step,
// sweeping one row per cycle while keeping the old neighbouring rows in side buffers.
module silife_grid #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int WRAP      = 0,
    parameter int GEN_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step,
    input  logic [8:0]              birth_mask,
    input  logic [8:0]              survive_mask,
    input  logic [WIDTH*HEIGHT-1:0] set_cells,
    input  logic [WIDTH*HEIGHT-1:0] clear_cells,
    output logic [WIDTH*HEIGHT-1:0] cells,
    output logic                    busy,
    output logic                    done,
    output logic [GEN_WIDTH-1:0]    generation,
    output logic                    extinct
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int RW = $clog2(HEIGHT);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         cells_q, cells_d;
    logic [RW-1:0]        row_q, row_d;
    logic [WIDTH-1:0]     prev_buf_q, prev_buf_d;
    logic [WIDTH-1:0]     row0_buf_q, row0_buf_d;
    logic [8:0]           birth_q, birth_d;
    logic [8:0]           survive_q, survive_d;
    logic [GEN_WIDTH-1:0] gen_q, gen_d;

    logic [WIDTH-1:0]     above, mid, below, new_row;
    int                   base;

    // Column neighbour lookup; x is allowed one step outside the row on either side.
    function automatic logic col_bit(input logic [WIDTH-1:0] row, input int x);
        logic [WIDTH-1:0] sh;
        if (x < 0) return (WRAP != 0) ? row[WIDTH-1] : 1'b0;
        if (x >= WIDTH) return (WRAP != 0) ? row[0] : 1'b0;
        sh = row >> x;
        return sh[0];
    endfunction

    // Rows above/below come from untouched state or the buffers holding old rows.
    always_comb begin
        base = int'(row_q) * WIDTH;
        mid  = WIDTH'(cells_q >> base);
        if (row_q != '0)      above = prev_buf_q;
        else if (WRAP != 0)   above = cells_q[N-1 -: WIDTH];
        else                  above = '0;
        if (row_q != LAST_ROW) below = WIDTH'(cells_q >> (base + WIDTH));
        else if (WRAP != 0)    below = row0_buf_q;
        else                   below = '0;
    end

    always_comb begin
        logic [3:0] cnt;
        cnt     = 4'd0;
        new_row = '0;
        for (int x = 0; x < WIDTH; x++) begin
            cnt = 4'd0;
            for (int dx = -1; dx <= 1; dx++) begin
                cnt = cnt + {3'b000, col_bit(above, x + dx)} + {3'b000, col_bit(below, x + dx)};
                if (dx != 0) cnt = cnt + {3'b000, col_bit(mid, x + dx)};
            end
            new_row[x] = mid[x] ? survive_q[cnt] : birth_q[cnt];
        end
    end

    always_comb begin
        state_d    = state_q;
        cells_d    = cells_q;
        row_d      = row_q;
        prev_buf_d = prev_buf_q;
        row0_buf_d = row0_buf_q;
        birth_d    = birth_q;
        survive_d  = survive_q;
        gen_d      = gen_q;
        case (state_q)
            IDLE: begin
                // Edits land on the same edge as a step, so the update sees the edited grid.
                cells_d = (cells_q | set_cells) & ~clear_cells;
                if (step) begin
                    birth_d   = birth_mask;
                    survive_d = survive_mask;
                    row_d     = '0;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                cells_d[base +: WIDTH] = new_row;
                prev_buf_d = mid;
                if (row_q == '0) row0_buf_d = mid;
                if (row_q == LAST_ROW) begin
                    state_d = DONE;
                    gen_d   = gen_q + 1'b1;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cells_q    <= '0;
            row_q      <= '0;
            prev_buf_q <= '0;
            row0_buf_q <= '0;
            birth_q    <= '0;
            survive_q  <= '0;
            gen_q      <= '0;
        end else begin
            state_q    <= state_d;
            cells_q    <= cells_d;
            row_q      <= row_d;
            prev_buf_q <= prev_buf_d;
            row0_buf_q <= row0_buf_d;
            birth_q    <= birth_d;
            survive_q  <= survive_d;
            gen_q      <= gen_d;
        end
    end

    assign cells      = cells_q;
    assign busy       = (state_q == UPDATE);
    assign done       = (state_q == DONE);
    assign generation = gen_q;
    assign extinct    = (cells_q == '0);

endmodule

// File: tb/tb_silife_grid.sv
// Bench for silife_grid: three 8x8 instances (bounded, toroidal, 2-bit generation)
// share one stimulus stream; a reference Life model feeds the expected queues.
module tb_silife_grid;
    localparam logic [63:0] BLINKER_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLINKER_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLOCK     = 64'h0000_0000_0006_0600;
    localparam logic [63:0] GLIDER    = 64'h0100_0000_0000_8302;
    localparam logic [63:0] GLIDER_SH = 64'h0000_0000_0007_0402;

    logic        clk = 1'b0;
    logic        reset, step;
    logic [8:0]  birth_mask, survive_mask;
    logic [63:0] set_cells, clear_cells;
    logic [63:0] cells0, cells1, cells2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic        extinct0, extinct1, extinct2;
    logic [15:0] gen0, gen1;
    logic [1:0]  gen2;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_w_q[$];
    logic [15:0] exp_gen_q[$];
    logic [1:0]  exp_gen2_q[$];

    logic [63:0] g0_m, g1_m;
    logic [15:0] gen0_m;
    logic [1:0]  gen2_m;

    always #5 clk = ~clk;

    silife_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(0), .GEN_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .step(step), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .set_cells(set_cells), .clear_cells(clear_cells),
        .cells(cells0), .busy(busy0), .done(done0), .generation(gen0), .extinct(extinct0));

    silife_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(1), .GEN_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .step(step), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .set_cells(set_cells), .clear_cells(clear_cells),
        .cells(cells1), .busy(busy1), .done(done1), .generation(gen1), .extinct(extinct1));

    silife_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(0), .GEN_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .step(step), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .set_cells(set_cells), .clear_cells(clear_cells),
        .cells(cells2), .busy(busy2), .done(done2), .generation(gen2), .extinct(extinct2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] life(input logic [63:0] g, input bit wrap,
                                         input logic [8:0] bm, input logic [8:0] sm);
        logic [63:0] r;
        int cnt, nx, ny;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        nx = x + dx;
                        ny = y + dy;
                        if (wrap) begin
                            nx = (nx + 8) % 8;
                            ny = (ny + 8) % 8;
                        end
                        if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8) cnt += int'(g[ny*8+nx]);
                    end
                end
                r[y*8+x] = g[y*8+x] ? sm[cnt] : bm[cnt];
            end
        end
        return r;
    endfunction

    task automatic edit(input logic [63:0] s, input logic [63:0] c);
        @(negedge clk);
        set_cells   = s;
        clear_cells = c;
        @(negedge clk);
        set_cells   = '0;
        clear_cells = '0;
        g0_m = (g0_m | s) & ~c;
        g1_m = (g1_m | s) & ~c;
        check("edit_cells", cells0, g0_m);
        check("edit_cells_w", cells1, g1_m);
    endtask

    task automatic do_step(input logic [63:0] pre_set, input bit mid_mask,
                           input bit mid_step, input logic [63:0] mid_set);
        int n;
        logic [8:0] bm, sm;
        @(negedge clk);
        set_cells = pre_set;
        step      = 1'b1;
        bm = birth_mask;
        sm = survive_mask;
        g0_m = life(g0_m | pre_set, 1'b0, bm, sm);
        g1_m = life(g1_m | pre_set, 1'b1, bm, sm);
        gen0_m++;
        gen2_m++;
        exp_q.push_back(g0_m);
        exp_w_q.push_back(g1_m);
        exp_gen_q.push_back(gen0_m);
        exp_gen2_q.push_back(gen2_m);
        @(negedge clk);
        step      = 1'b0;
        set_cells = '0;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            if (mid_mask && n == 2) survive_mask = 9'h000;
            if (mid_step && n == 3) step = 1'b1;
            if (n == 4) step = 1'b0;
            if (n == 3) set_cells = mid_set;
            @(negedge clk);
        end
        step         = 1'b0;
        set_cells    = '0;
        survive_mask = sm;
        check("busy_cycles", 64'(n), 64'd8);
        check("done_pulse", {63'd0, done0}, 64'd1);
        check("cells", cells0, exp_q.pop_front());
        check("cells_wrap", cells1, exp_w_q.pop_front());
        check("generation", {48'd0, gen0}, {48'd0, exp_gen_q.pop_front()});
        check("generation_w2", {62'd0, gen2}, {62'd0, exp_gen2_q.pop_front()});
        @(negedge clk);
        check("done_drop", {62'd0, done0, busy0}, 64'd0);
    endtask

    task automatic reset_mid;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("no_done_pre_rst", {63'd0, done0}, 64'd0);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        g0_m = '0;
        g1_m = '0;
        gen0_m = '0;
        gen2_m = '0;
        check("rst_cells", cells0, 64'd0);
        check("rst_gen", {48'd0, gen0}, 64'd0);
        check("rst_gen2", {62'd0, gen2}, 64'd0);
        check("rst_busy_done", {62'd0, busy0, done0}, 64'd0);
        check("rst_extinct", {63'd0, extinct0}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_done_post_rst", {62'd0, done0, busy0}, 64'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        step = 1'b0;
        birth_mask = 9'h008;
        survive_mask = 9'h00C;
        set_cells = '0;
        clear_cells = '0;
        g0_m = '0;
        g1_m = '0;
        gen0_m = '0;
        gen2_m = '0;
        repeat (3) @(negedge clk);
        check("reset_cells", cells0, 64'd0);
        check("reset_busy_done", {62'd0, busy0, done0}, 64'd0);
        check("reset_gen", {48'd0, gen0}, 64'd0);
        check("reset_extinct", {63'd0, extinct0}, 64'd1);
        reset = 1'b1;

        // Blinker loaded on the same edge as the step.
        do_step(BLINKER_V, 1'b0, 1'b0, 64'd0);
        check("blinker_h", cells0, BLINKER_H);
        check("blinker_gen1", {48'd0, gen0}, 64'd1);
        do_step(64'd0, 1'b0, 1'b0, 64'd0);
        check("blinker_v", cells0, BLINKER_V);

        edit(64'd1, 64'd1);
        check("set_clr_prio", cells0 & 64'd1, 64'd0);
        edit(64'd0, '1);
        check("extinct_clear", {63'd0, extinct0}, 64'd1);

        // Still life, rule change, step pulse and set_cells all during the update.
        edit(BLOCK, 64'd0);
        check("extinct_block", {63'd0, extinct0}, 64'd0);
        do_step(64'd0, 1'b1, 1'b1, 64'h8000_0000_0000_0000);
        check("block_kept", cells0, BLOCK);
        check("block_gen", {48'd0, gen0}, 64'd3);
        check("busy_step_ignored", {62'd0, busy0, done0}, 64'd0);

        edit(64'd0, '1);
        edit(GLIDER, 64'd0);
        repeat (4) do_step(64'd0, 1'b0, 1'b0, 64'd0);
        check("glider_shift", cells1, GLIDER_SH);
        check("glider_pop", 64'($countones(cells1)), 64'd5);
        check("wrap_differs", {63'd0, cells0 != cells1}, 64'd1);

        // Random grid and rules against the reference model.
        for (int k = 0; k < 3; k++) begin
            edit({$urandom, $urandom}, '1);
            edit({$urandom, $urandom}, 64'd0);
            birth_mask   = 9'($urandom_range(0, 511));
            survive_mask = 9'($urandom_range(0, 511));
            do_step(64'd0, 1'b0, 1'b0, 64'd0);
        end
        birth_mask   = 9'h008;
        survive_mask = 9'h00C;

        edit(64'd0, '1);
        edit(BLINKER_V, 64'd0);
        reset_mid;
        do_step(BLINKER_V, 1'b0, 1'b0, 64'd0);
        check("post_rst_blinker", cells0, BLINKER_H);
        repeat (4) do_step(64'd0, 1'b0, 1'b0, 64'd0);
        check("gen2_wrapped", {62'd0, gen2}, 64'd1);
        check("gen16_five", {48'd0, gen0}, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
